cpu_core: RTL

//  Parametrised multi-cycle successor of the single-cycle cpu datapath. It fetches 16-bit

---
 rtl/cpu_core.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_core.sv
// Multi-cycle accumulator-free core: 16-bit instructions, small register file, zx/nx/zy/ny/f/no ALU,
// separate instruction and data ports with req/ready handshakes.
module cpu_core #(
  parameter int                WIDTH    = 16,
  parameter int                NUM_REGS = 3,
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic             dmem_we,
  output logic             dmem_req,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [1:0] OP_SYS = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  state_t            state, next_state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [WIDTH-1:0]  regs [0:3];
  logic [WIDTH-1:0]  alu_q, maddr, mwdata;
  logic              we_q, z;

  logic [1:0]        op, rd, ra, rb;
  logic              zx, nx, zy, ny, fsel, no;
  logic [WIDTH-1:0]  rf_a, rf_b, x, y, alu_res;
  logic              unused_bits;

  assign op = ir[15:14];
  assign rd = ir[13:12];
  assign ra = ir[11:10];
  assign rb = ir[9:8];
  assign {zx, nx, zy, ny, fsel, no} = ir[7:2];
  assign unused_bits = ^ir[1:0];

  // Index 0 and indices beyond NUM_REGS behave as a hard-wired zero register.
  function automatic logic reg_ok(input logic [1:0] idx);
    return (idx != 2'd0) && (int'(idx) <= NUM_REGS);
  endfunction

  assign rf_a = reg_ok(ra) ? regs[ra] : '0;
  assign rf_b = reg_ok(rb) ? regs[rb] : '0;

  // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    x = rf_a;
    y = rf_b;
    if (zx) x = '0;
    if (nx) x = ~x;
    if (zy) y = '0;
    if (ny) y = ~y;
    alu_res = fsel ? (x + y) : (x & y);
    if (no) alu_res = ~alu_res;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: if (imem_ready) next_state = S_EXEC;
      S_EXEC: begin
        if (op == OP_SYS && ra == 2'd0)      next_state = S_HALT;
        else if (op == OP_LD || op == OP_ST) next_state = S_MEM;
        else                                 next_state = S_FETCH;
      end
      S_MEM:   if (dmem_ready) next_state = S_FETCH;
      default: next_state = S_HALT;
    endcase
  end

  // Gating with reset keeps the fetch request low while reset is held.
  always_comb begin
    imem_req = (state == S_FETCH) && !reset;
    dmem_req = (state == S_MEM);
    halted   = (state == S_HALT);
  end

  // NOTE: the register file is reset explicitly because software relies on registers starting at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      alu_q  <= '0;
      z      <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      we_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem_ready) ir <= imem_rdata;
        S_EXEC: begin
          case (op)
            OP_ALU: begin
              if (reg_ok(rd)) regs[rd] <= alu_res;
              alu_q <= alu_res;
              z     <= (alu_res == '0);
              pc    <= pc + PC_W'(1);
            end
            OP_SYS: if (ra != 2'd0) pc <= z ? PC_W'(rf_a) : pc + PC_W'(1);
            default: begin
              maddr  <= rf_a;
              mwdata <= rf_b;
              we_q   <= (op == OP_ST);
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (!we_q && reg_ok(rd)) regs[rd] <= dmem_rdata;
            pc <= pc + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = maddr;
  assign dmem_wdata = mwdata;
  assign dmem_we    = we_q && dmem_req;
  assign alu_out    = alu_q;

endmodule
